// File: rtl/uart_receiver.sv
// 8N1 UART receive path: 2-flop synchronizer, 16x oversampling tick generator,
// mid-bit sampling receive FSM and a show-ahead FIFO with almost-full flag.
module uart_receiver #(
    parameter int FIFO_DEPTH = 32,
    parameter int DIV0       = 326,
    parameter int DIV1       = 163,
    parameter int DIV2       = 54,
    parameter int DIV3       = 27
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       uart_rx_i,
    input  logic [1:0] baudrate_select_i,
    input  logic [5:0] data_buffer_full_tresh_i,
    input  logic       data_read_i,
    output logic [7:0] data_o,
    output logic       data_available_o,
    output logic       data_buffer_full_o,
    output logic       frame_error_o,
    output logic       overrun_o
);
    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [6:0] DEPTH_C = 7'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
    state_t state, state_next;

    logic        sync_1, rx_s;
    logic [15:0] div_sel, div_q, tick_cnt;
    logic        tick;
    logic [3:0]  sample_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_q;

    logic clear_counts, latch_div, shift_en, push_req, frame_err_req;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [6:0]    count, count_next, eff_thresh;
    logic          do_pop, do_push, overrun_req;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_1 <= uart_rx_i;
            rx_s   <= sync_1;
        end
    end

    always_comb begin
        case (baudrate_select_i)
            2'b00:   div_sel = 16'(DIV0);
            2'b01:   div_sel = 16'(DIV1);
            2'b10:   div_sel = 16'(DIV2);
            default: div_sel = 16'(DIV3);
        endcase
    end

    assign tick = (state != IDLE) && (state != WAIT_IDLE) && (tick_cnt == div_q - 16'd1);

    // The divider is frozen for the whole frame once a start bit is seen.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            div_q    <= 16'(DIV0);
            tick_cnt <= 16'd0;
        end else begin
            if (latch_div) begin
                div_q <= div_sel;
            end
            if (state == IDLE || state == WAIT_IDLE || tick) begin
                tick_cnt <= 16'd0;
            end else begin
                tick_cnt <= tick_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!rx_s) state_next = START;
            START:     if (tick && sample_cnt == 4'd7) state_next = rx_s ? IDLE : DATA;
            DATA:      if (tick && sample_cnt == 4'd15 && bit_cnt == 3'd7) state_next = STOP;
            STOP:      if (tick && sample_cnt == 4'd15) state_next = rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_s) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        clear_counts  = 1'b0;
        latch_div     = 1'b0;
        shift_en      = 1'b0;
        push_req      = 1'b0;
        frame_err_req = 1'b0;
        case (state)
            IDLE: begin
                clear_counts = 1'b1;
                latch_div    = !rx_s;
            end
            START: clear_counts = tick && (sample_cnt == 4'd7) && !rx_s;
            DATA:  shift_en = tick && (sample_cnt == 4'd15);
            STOP: begin
                push_req      = tick && (sample_cnt == 4'd15) && rx_s;
                frame_err_req = tick && (sample_cnt == 4'd15) && !rx_s;
            end
            default: ;
        endcase
    end

    // Bits arrive LSB first, so each new sample enters at the top and shifts down.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sample_cnt <= 4'd0;
            bit_cnt    <= 3'd0;
            shift_q    <= 8'h00;
        end else begin
            if (clear_counts) begin
                sample_cnt <= 4'd0;
                bit_cnt    <= 3'd0;
            end else begin
                if (tick) sample_cnt <= sample_cnt + 4'd1;
                if (shift_en) bit_cnt <= bit_cnt + 3'd1;
            end
            if (shift_en) begin
                shift_q <= {rx_s, shift_q[7:1]};
            end
        end
    end

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign do_pop      = data_read_i && (count != 7'd0);
    assign do_push     = push_req && ((count != DEPTH_C) || do_pop);
    assign overrun_req = push_req && (count == DEPTH_C) && !do_pop;

    always_comb begin
        count_next = count + 7'(do_push) - 7'(do_pop);
        if (data_buffer_full_tresh_i == 6'd0 || 7'(data_buffer_full_tresh_i) > DEPTH_C) begin
            eff_thresh = DEPTH_C;
        end else begin
            eff_thresh = 7'(data_buffer_full_tresh_i);
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i && do_push) begin
            mem[wr_ptr] <= shift_q;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= 7'd0;
            data_buffer_full_o <= 1'b0;
            frame_error_o      <= 1'b0;
            overrun_o          <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count              <= count_next;
            data_buffer_full_o <= (count_next >= eff_thresh);
            frame_error_o      <= frame_err_req;
            overrun_o          <= overrun_req;
        end
    end

    assign data_available_o = (count != 7'd0);
    assign data_o           = data_available_o ? mem[rd_ptr] : 8'h00;

endmodule
